// File: rtl/regfile_bypass_queue.sv
// Integer register file fronted by a shift queue of in-flight results.
// Read ports return the youngest matching queue entry, else the retired register value.
module regfile_bypass_queue #(
    parameter int RegFileSize   = 32,
    parameter int RegAddrWidth  = 5,
    parameter int DataWidth     = 32,
    parameter int BypassDepth   = 3,
    parameter int ReadPortCount = 2,
    parameter bit EnableBypass  = 1'b1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  stall,
    input  logic                                  writeValid,
    input  logic [RegAddrWidth-1:0]               writeAddr,
    input  logic [DataWidth-1:0]                  writeValue,
    input  logic [ReadPortCount*RegAddrWidth-1:0] readAddr,
    output logic [ReadPortCount*DataWidth-1:0]    readValue,
    output logic [ReadPortCount-1:0]              readHit,
    output logic [$clog2(BypassDepth+1)-1:0]      occupancy
);
    localparam int OccWidth = $clog2(BypassDepth+1);

    logic                    r_q_valid [BypassDepth];
    logic [RegAddrWidth-1:0] r_q_addr  [BypassDepth];
    logic [DataWidth-1:0]    r_q_value [BypassDepth];
    logic [DataWidth-1:0]    r_regs    [RegFileSize];

    logic [RegAddrWidth-1:0] w_read_addr  [ReadPortCount];
    logic [DataWidth-1:0]    w_read_value [ReadPortCount];
    logic                    w_read_hit   [ReadPortCount];
    logic [OccWidth-1:0]     w_occupancy;
    logic                    w_push_valid;
    logic                    w_retire;

    // Writes to x0 enter as bubbles so x0 can never be forwarded or retired.
    assign w_push_valid = writeValid && (writeAddr != '0);
    assign w_retire     = !stall && r_q_valid[BypassDepth-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < BypassDepth; s++) begin
                r_q_valid[s] <= 1'b0;
                r_q_addr[s]  <= '0;
                r_q_value[s] <= '0;
            end
        end else if (!stall) begin
            r_q_valid[0] <= w_push_valid;
            r_q_addr[0]  <= writeAddr;
            r_q_value[0] <= writeValue;
            for (int s = 1; s < BypassDepth; s++) begin
                r_q_valid[s] <= r_q_valid[s-1];
                r_q_addr[s]  <= r_q_addr[s-1];
                r_q_value[s] <= r_q_value[s-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < RegFileSize; r++) begin
                r_regs[r] <= '0;
            end
        end else if (w_retire) begin
            r_regs[r_q_addr[BypassDepth-1]] <= r_q_value[BypassDepth-1];
        end
    end

    generate
        for (genvar gi = 0; gi < ReadPortCount; gi++) begin : g_port
            assign w_read_addr[gi]                        = readAddr[gi*RegAddrWidth +: RegAddrWidth];
            assign readValue[gi*DataWidth +: DataWidth]   = w_read_value[gi];
            assign readHit[gi]                            = w_read_hit[gi];
        end
    endgenerate

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        for (int p = 0; p < ReadPortCount; p++) begin
            w_read_value[p] = r_regs[w_read_addr[p]];
            w_read_hit[p]   = 1'b0;
            if (EnableBypass) begin
                for (int s = BypassDepth - 1; s >= 0; s--) begin
                    if (r_q_valid[s] && (r_q_addr[s] == w_read_addr[p])) begin
                        w_read_value[p] = r_q_value[s];
                        w_read_hit[p]   = 1'b1;
                    end
                end
            end
            if (w_read_addr[p] == '0) begin
                w_read_value[p] = '0;
                w_read_hit[p]   = 1'b0;
            end
        end
    end

    always_comb begin
        w_occupancy = '0;
        for (int s = 0; s < BypassDepth; s++) begin
            w_occupancy = w_occupancy + OccWidth'(r_q_valid[s]);
        end
    end

    assign occupancy = w_occupancy;

endmodule

// File: tb/tb_regfile_bypass_queue.sv
// Scoreboard bench: three configurations share one stimulus stream and are checked
// against a write-history model (entries younger than the depth are in flight).
module tb_regfile_bypass_queue;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            stall = 1'b0;
    logic            writeValid = 1'b0;
    logic [4:0]      writeAddr = '0;
    logic [63:0]     writeValue = '0;
    logic [3:0][4:0] ra = '0;

    logic [63:0]  rv0, rv1;
    logic [1:0]   rh0, rh1, oc0, oc1;
    logic [255:0] rv2;
    logic [3:0]   rh2;
    logic [0:0]   oc2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_bypass_queue dut0 (
        .clk(clk), .rst(rst), .stall(stall), .writeValid(writeValid),
        .writeAddr(writeAddr), .writeValue(writeValue[31:0]), .readAddr(ra[1:0]),
        .readValue(rv0), .readHit(rh0), .occupancy(oc0)
    );

    regfile_bypass_queue #(.EnableBypass(1'b0)) dut1 (
        .clk(clk), .rst(rst), .stall(stall), .writeValid(writeValid),
        .writeAddr(writeAddr), .writeValue(writeValue[31:0]), .readAddr(ra[1:0]),
        .readValue(rv1), .readHit(rh1), .occupancy(oc1)
    );

    regfile_bypass_queue #(.BypassDepth(1), .ReadPortCount(4), .DataWidth(64)) dut2 (
        .clk(clk), .rst(rst), .stall(stall), .writeValid(writeValid),
        .writeAddr(writeAddr), .writeValue(writeValue), .readAddr(ra),
        .readValue(rv2), .readHit(rh2), .occupancy(oc2)
    );

    // Accepted pushes, youngest first; bubbles included so age equals index.
    typedef struct {
        bit          valid;
        logic [4:0]  addr;
        logic [63:0] value;
    } ent_t;
    ent_t hist[$];

    typedef struct {
        logic [1:0][31:0] v0;
        logic [1:0]       h0;
        logic [1:0]       o0;
        logic [1:0][31:0] v1;
        logic [1:0]       h1;
        logic [1:0]       o1;
        logic [3:0][63:0] v2;
        logic [3:0]       h2;
        logic             o2;
    } exp_t;
    exp_t sb[$];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    // In flight when younger than depth; otherwise the youngest such write is the register value.
    function automatic void model_read(input int depth, input bit byp, input logic [4:0] a,
                                       output logic [63:0] v, output bit h);
        v = '0;
        h = 1'b0;
        if (a == 5'd0) return;
        foreach (hist[k]) begin
            if (hist[k].valid && hist[k].addr == a && (byp || k >= depth)) begin
                v = hist[k].value;
                h = byp && (k < depth);
                return;
            end
        end
    endfunction

    function automatic int model_occ(input int depth);
        int n = 0;
        foreach (hist[k]) if (k < depth && hist[k].valid) n++;
        return n;
    endfunction

    task automatic step(input bit r, input bit st, input bit wv, input logic [4:0] wa,
                        input logic [63:0] wd, input logic [3:0][4:0] rda);
        exp_t e;
        logic [63:0] v;
        bit h;
        ent_t ent;
        rst = r; stall = st; writeValid = wv; writeAddr = wa; writeValue = wd; ra = rda;
        if (r) hist.delete();
        for (int p = 0; p < 2; p++) begin
            model_read(3, 1'b1, rda[p], v, h); e.v0[p] = v[31:0]; e.h0[p] = h;
            model_read(3, 1'b0, rda[p], v, h); e.v1[p] = v[31:0]; e.h1[p] = h;
        end
        for (int p = 0; p < 4; p++) begin
            model_read(1, 1'b1, rda[p], v, h); e.v2[p] = v; e.h2[p] = h;
        end
        e.o0 = 2'(model_occ(3));
        e.o1 = 2'(model_occ(3));
        e.o2 = 1'(model_occ(1));
        sb.push_back(e);
        @(posedge clk);
        if (!r && !st) begin
            ent.valid = wv && (wa != 5'd0);
            ent.addr  = wa;
            ent.value = wd;
            hist.push_front(ent);
        end
        #1;
    endtask

    function automatic logic [3:0][4:0] all_ports(input logic [4:0] a);
        logic [3:0][4:0] x;
        for (int p = 0; p < 4; p++) x[p] = a;
        return x;
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("d0_val_p%0d", p), {32'd0, rv0[p*32 +: 32]}, {32'd0, e.v0[p]});
                chk($sformatf("d1_val_p%0d", p), {32'd0, rv1[p*32 +: 32]}, {32'd0, e.v1[p]});
            end
            for (int p = 0; p < 4; p++) begin
                chk($sformatf("d2_val_p%0d", p), rv2[p*64 +: 64], e.v2[p]);
            end
            chk("d0_hit", {62'd0, rh0}, {62'd0, e.h0});
            chk("d1_hit", {62'd0, rh1}, {62'd0, e.h1});
            chk("d2_hit", {60'd0, rh2}, {60'd0, e.h2});
            chk("d0_occ", {62'd0, oc0}, {62'd0, e.o0});
            chk("d1_occ", {62'd0, oc1}, {62'd0, e.o1});
            chk("d2_occ", {63'd0, oc2}, {63'd0, e.o2});
        end
    end

    initial begin
        logic [3:0][4:0] rda;
        logic [63:0] big;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 1'b0, 5'd0, 64'd0, all_ports(5'd5));
        chk("reset_occ", {62'd0, oc0}, 64'd0);
        step(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, all_ports(5'd5));

        // Forwarding then retire of x5
        step(1'b0, 1'b0, 1'b1, 5'd5, 64'hDEADBEEF, all_ports(5'd5));
        chk("fwd_c1_val", {32'd0, rv0[31:0]}, 64'hDEADBEEF);
        chk("fwd_c1_hit", {63'd0, rh0[0]}, 64'd1);
        chk("nobyp_c1_val", {32'd0, rv1[31:0]}, 64'd0);
        step(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, all_ports(5'd5));
        chk("depth1_retired_hit", {63'd0, rh2[0]}, 64'd0);
        chk("depth1_retired_val", rv2[63:0], 64'hDEADBEEF);
        step(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, all_ports(5'd5));
        chk("fwd_c3_hit", {63'd0, rh0[1]}, 64'd1);
        step(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, all_ports(5'd5));
        chk("fwd_c4_val", {32'd0, rv0[31:0]}, 64'hDEADBEEF);
        chk("fwd_c4_hit", {63'd0, rh0[0]}, 64'd0);
        chk("nobyp_c4_val", {32'd0, rv1[31:0]}, 64'hDEADBEEF);

        // Youngest-wins priority on x7
        step(1'b0, 1'b0, 1'b1, 5'd7, 64'h11, all_ports(5'd7));
        step(1'b0, 1'b0, 1'b1, 5'd7, 64'h22, all_ports(5'd7));
        step(1'b0, 1'b0, 1'b1, 5'd7, 64'h33, all_ports(5'd7));
        chk("prio_p0", {32'd0, rv0[31:0]}, 64'h33);
        chk("prio_p1", {32'd0, rv0[63:32]}, 64'h33);
        repeat (3) step(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, all_ports(5'd7));
        chk("prio_retired_val", {32'd0, rv0[31:0]}, 64'h33);
        chk("prio_retired_hit", {62'd0, rh0}, 64'd0);

        // x0 writes are dropped
        step(1'b0, 1'b0, 1'b1, 5'd0, 64'hFFFFFFFF, all_ports(5'd0));
        chk("x0_occ", {62'd0, oc0}, 64'd0);
        chk("x0_val", {32'd0, rv0[31:0]}, 64'd0);

        // Stall holds the queue and ignores the push
        step(1'b0, 1'b1, 1'b1, 5'd3, 64'h3333, all_ports(5'd3));
        chk("stall1_occ", {62'd0, oc0}, 64'd0);
        step(1'b0, 1'b1, 1'b1, 5'd3, 64'h3333, all_ports(5'd3));
        chk("stall2_occ", {62'd0, oc0}, 64'd0);
        step(1'b0, 1'b0, 1'b1, 5'd3, 64'h3333, all_ports(5'd3));
        chk("unstall_occ", {62'd0, oc0}, 64'd1);
        chk("unstall_val", {32'd0, rv0[31:0]}, 64'h3333);

        // Bypass disabled: x9 invisible until retired
        step(1'b0, 1'b0, 1'b1, 5'd9, 64'hABCD, all_ports(5'd9));
        step(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, all_ports(5'd9));
        step(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, all_ports(5'd9));
        chk("nobyp_pending_val", {32'd0, rv1[31:0]}, 64'd0);
        step(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, all_ports(5'd9));
        chk("nobyp_retired_val", {32'd0, rv1[31:0]}, 64'hABCD);
        chk("nobyp_hit", {62'd0, rh1}, 64'd0);

        // Depth 1, four 64-bit ports
        big = 64'h0123456789ABCDEF;
        step(1'b0, 1'b0, 1'b1, 5'd2, big, all_ports(5'd2));
        chk("d1cfg_hit", {60'd0, rh2}, 64'hF);
        chk("d1cfg_p3_val", rv2[255:192], big);
        step(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, all_ports(5'd2));
        chk("d1cfg_retired_hit", {60'd0, rh2}, 64'd0);
        chk("d1cfg_retired_val", rv2[127:64], big);

        // Reset mid-run with three valid slots
        step(1'b0, 1'b0, 1'b1, 5'd5, 64'h1, all_ports(5'd5));
        step(1'b0, 1'b0, 1'b1, 5'd6, 64'h2, all_ports(5'd5));
        step(1'b0, 1'b0, 1'b1, 5'd7, 64'h3, all_ports(5'd5));
        chk("full_occ", {62'd0, oc0}, 64'd3);
        step(1'b1, 1'b0, 1'b0, 5'd0, 64'd0, all_ports(5'd5));
        chk("midreset_occ", {62'd0, oc0}, 64'd0);
        step(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, all_ports(5'd5));
        chk("postreset_val", {32'd0, rv0[31:0]}, 64'd0);
        chk("postreset_hit", {62'd0, rh0}, 64'd0);

        // Randomised traffic over a small address range to provoke collisions
        for (int i = 0; i < 600; i++) begin
            for (int p = 0; p < 4; p++) rda[p] = 5'($urandom_range(7));
            step($urandom_range(99) == 0, $urandom_range(4) == 0, $urandom_range(3) != 0,
                 5'($urandom_range(7)), {$urandom, $urandom}, rda);
        end

        rst = 1'b0; stall = 1'b0; writeValid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_bypass_queue.md
Name: regfile_bypass_queue

Overview:
- Parametrised successor of the fixed 3-deep, 2-read-port bypass configuration.
- Integer register file with a built-in shift queue of in-flight results. Read ports forward from that queue youngest-first.
- Sits between the execute/writeback stages and the decode/register-read stage.
- Generalises depth, port count and data width, and adds a stall hold, a bypass-disable mode and per-port hit flags.

Parameters:
- RegFileSize, 32, number of architectural registers; register 0 is hardwired to zero.
- RegAddrWidth, 5, register address width; must equal clog2(RegFileSize).
- DataWidth, 32, register data width.
- BypassDepth, 3, number of in-flight queue slots; must be ≥1.
- ReadPortCount, 2, number of independent read ports; must be ≥1.
- EnableBypass, 1, 1 = forward from the queue; 0 = reads see only retired register contents.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- stall  input  1  freezes the queue and register file for this cycle.
- writeValid  input  1  pushes a result into queue slot 0.
- writeAddr  input  RegAddrWidth  destination register of the pushed result.
- writeValue  input  DataWidth  pushed result value.
- readAddr  input  ReadPortCount*RegAddrWidth  per-port source register; port p occupies bits [p*RegAddrWidth +: RegAddrWidth].
- readValue  output  ReadPortCount*DataWidth  per-port operand value.
- readHit  output  ReadPortCount  per-port flag: value came from the queue, not the register file.
- occupancy  output  clog2(BypassDepth+1)  number of valid queue slots.

Behaviour:
- Reset (async, rst=1): all registers cleared to 0; all queue valid bits cleared.
  - While rst=1: readValue=0 for every port, readHit=0, occupancy=0.
  - Reset in the middle of operation discards all in-flight entries and all retired values.
- Queue: slot 0 is the youngest entry, slot BypassDepth-1 the oldest. Each slot holds {valid, addr, value}.
- On a rising edge with stall=0:
  - Slot i+1 takes the contents of slot i.
  - Slot 0 takes {writeValid && writeAddr!=0, writeAddr, writeValue}.
  - If the oldest slot was valid, its value is written to register[addr] on the same edge.
- Writes to address 0 are dropped at push time; the slot enters as invalid.
- On a rising edge with stall=1: queue and register file hold.
  - A push presented that cycle is ignored; the producer must hold writeValid until the stall clears.
  - No retire occurs.
- Reads are combinational, with no latency.
  - readAddr=0 gives 0 with hit=0.
  - Otherwise, with EnableBypass=1, readValue comes from the lowest-indexed (youngest) valid slot whose addr matches, and readHit=1.
  - With no match, readValue = register[readAddr] and readHit=0.
  - With EnableBypass=0, the queue is never searched and readHit is always 0.
- Same-cycle push and read: the pushed value is not visible until after the edge. No write-input-to-read path exists.
- Retire and read in the same cycle: the read sees the value still in the oldest slot (hit=1). After the edge it sees the register file value, which is identical.
- Multiple matching slots: the youngest wins. Older duplicates still retire in order, so the final register value is the youngest write.
- occupancy counts the valid slots after each edge. It is saturated by construction at BypassDepth.
- All read ports are independent. Identical addresses on different ports return identical data.

Test Plan:
- Reset: rst=1 mid-run with 3 valid slots -> occupancy=0 immediately. After release, a read of x5 returns 0 with hit=0.
- Forwarding/retire: push x5=0xDEADBEEF at cycle 0, no stall. Cycles 1-3: port0 readAddr=5 -> 0xDEADBEEF, hit=1. Cycle 4: same value, hit=0 (retired).
- Priority: push x7=0x11, x7=0x22, x7=0x33 on consecutive cycles -> next cycle readValue=0x33 on both ports. After 3 more idle cycles: 0x33 with hit=0.
- x0: push x0=0xFFFFFFFF -> occupancy stays 0 and a read of x0 returns 0. Push x3 with stall=1 for 2 cycles -> queue unchanged. Push accepted on the first stall=0 edge.
- Bypass disabled: EnableBypass=0, push x9=0xABCD -> reads return 0 for BypassDepth cycles, then 0xABCD, with hit always 0.
- Parametrisation: BypassDepth=1, ReadPortCount=4, DataWidth=64. Push x2 = 64'h0123456789ABCDEF -> all 4 ports reading x2 get the value next cycle (hit=1), and the cycle after that with hit=0.
